dpram_stream_reader: RTL

- Read-side client for one port of the team's dual-port block RAM: given base address and length, drives the RAM port with sequential read requests.
- Returns the words as a valid/ready stream with last-beat marking.
- Absorbs the RAM's one-cycle registered read latency and downstream backpressure with a 2-entry skid FIFO; full throughput when the sink is always ready.
- Typical use: framebuffer/line-buffer scanout into pixel pipelines.

---
 rtl/dpram_stream_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dpram_stream_reader.sv
// Sequential read client for one dual-port RAM port; streams the words out
// as valid/ready beats through a 2-entry skid FIFO that hides the RAM latency.
module dpram_stream_reader #(
    parameter int DP = 512,
    parameter int DW = 8,
    parameter int AW = $clog2(DP),
    parameter int LW = AW + 1
) (
    input  logic          CLKA,
    input  logic          rstb,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          ram_ce,
    output logic          ram_we,
    output logic          ram_rst,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [LW-1:0]          remaining_q, remaining_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic [1:0]             count_q, count_d;
    logic [1:0][DW-1:0]     fdata_q, fdata_d;
    logic [1:0]             flast_q, flast_d;
    logic                   issue;
    logic                   pop;
    logic [2:0]             occ;

    always_comb begin
        pop   = (count_q != 2'd0) && m_ready;
        // Words already owed to the FIFO after this cycle's pop; must leave room for one more.
        occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == RUN) && (remaining_q != '0) && (occ < 3'd2);

        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == LW'(1));

        if (issue) begin
            addr_d      = (addr_q == AW'(DP - 1)) ? '0 : addr_q + AW'(1);
            remaining_d = remaining_q - LW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base;
                    remaining_d = len;
                    state_d     = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && (remaining_q == LW'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && flast_q[0]) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        fdata_d = fdata_q;
        flast_d = flast_q;
        count_d = count_q;
        if (pop) begin
            fdata_d[0] = fdata_q[1];
            flast_d[0] = flast_q[1];
            flast_d[1] = 1'b0;
            count_d    = count_q - 2'd1;
        end
        // Push lands behind whatever survives this cycle's pop.
        if (inflight_q) begin
            fdata_d[count_d[0]] = ram_rdata;
            flast_d[count_d[0]] = inflight_last_q;
            count_d             = count_d + 2'd1;
        end
    end

    always_ff @(posedge CLKA) begin
        if (rstb) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= '0;
            fdata_q         <= '0;
            flast_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            fdata_q         <= fdata_d;
            flast_q         <= flast_d;
        end
    end

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign ram_ce   = issue;
    assign ram_we   = 1'b0;
    assign ram_rst  = 1'b0;
    assign ram_addr = addr_q;
    assign m_valid  = (count_q != 2'd0);
    assign m_data   = fdata_q[0];
    assign m_last   = m_valid && flast_q[0];

endmodule
